// File: rtl/i2s_sched_pkg.sv
// Shared types, default sizing and frame-index helpers for the I2S frame scheduler.
package i2s_sched_pkg;

    localparam int unsigned CIRC_BUF_BITS_DEF  = 3;
    localparam int unsigned FRAME_BITS_DEF     = 8;
    localparam int unsigned TARGET_LAG_DEF     = 2;
    localparam int unsigned MIN_LAG_DEF        = 1;
    localparam int unsigned MAX_LAG_DEF        = 6;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_RUN    = 2'd2,
        ST_RESYNC = 2'd3
    } sched_state_e;

    function automatic int unsigned addr_width(input int unsigned circ_bits,
                                               input int unsigned frame_bits);
        return circ_bits + frame_bits;
    endfunction

    // Write-to-read distance in frames, wrapped to the circular buffer size.
    function automatic logic [31:0] frame_lag(input logic [31:0] write_idx,
                                              input logic [31:0] read_idx,
                                              input int unsigned circ_bits);
        logic [31:0] mask;
        mask = (32'd1 << circ_bits) - 32'd1;
        return (write_idx - read_idx) & mask;
    endfunction

    function automatic logic [31:0] next_frame_idx(input logic [31:0] idx,
                                                   input int unsigned circ_bits);
        logic [31:0] mask;
        mask = (32'd1 << circ_bits) - 32'd1;
        return (idx + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/frame_watchdog.sv
// Producer-stall timeout: counts cycles since the last clear, pulses expire_o once
// on reaching the terminal count and then holds there until the next clear.
module frame_watchdog
    import i2s_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic expire_o
);

    localparam int unsigned        CNT_W        = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]   TERMINAL     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   PRE_TERMINAL = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] count_r;
    logic             expire_r;

    // Counter and expiry pulse; a clear in the expiry cycle suppresses the pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_r  <= {CNT_W{1'b0}};
            expire_r <= 1'b0;
        end else if (clear_i) begin
            count_r  <= {CNT_W{1'b0}};
            expire_r <= 1'b0;
        end else if (count_r != TERMINAL) begin
            count_r  <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            expire_r <= (count_r == PRE_TERMINAL);
        end else begin
            count_r  <= count_r;
            expire_r <= 1'b0;
        end
    end

    assign expire_o = expire_r;

endmodule

// File: rtl/i2s_frame_scheduler.sv
// Sequences the I2S transmitter against the producer's circular frame buffer.
// Optional resync statistics counter enabled by I2S_FRAME_SCHED_STATS_EN.
module i2s_frame_scheduler
    import i2s_sched_pkg::*;
#(
    parameter int unsigned CIRC_BUF_BITS  = CIRC_BUF_BITS_DEF,
    parameter int unsigned FRAME_BITS     = FRAME_BITS_DEF,
    parameter int unsigned TARGET_LAG     = TARGET_LAG_DEF,
    parameter int unsigned MIN_LAG        = MIN_LAG_DEF,
    parameter int unsigned MAX_LAG        = MAX_LAG_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              frame_valid_i,
    input  logic [CIRC_BUF_BITS-1:0]          frame_idx_i,
    input  logic [CIRC_BUF_BITS+FRAME_BITS-1:0] ram_read_addr_i,
    input  logic                              i2s_running_i,
    output logic                              resync_req_o,
    output logic [CIRC_BUF_BITS-1:0]          last_good_frame_idx_o,
    output logic                              lock_o,
    output logic                              underrun_o,
    output logic [7:0]                        resync_count_o
);

    localparam int unsigned               ADDR_W      = addr_width(CIRC_BUF_BITS, FRAME_BITS);
    localparam int unsigned               PCNT_W      = $clog2(TARGET_LAG + 1);
    localparam logic [PCNT_W-1:0]         PCNT_TARGET = PCNT_W'(TARGET_LAG);
    localparam logic [PCNT_W-1:0]         PCNT_ONE    = PCNT_W'(1);
    localparam logic [PCNT_W-1:0]         PCNT_ZERO   = {PCNT_W{1'b0}};
    localparam logic [CIRC_BUF_BITS-1:0]  LAG_MIN     = CIRC_BUF_BITS'(MIN_LAG);
    localparam logic [CIRC_BUF_BITS-1:0]  LAG_MAX     = CIRC_BUF_BITS'(MAX_LAG);

    sched_state_e              state_r, state_next_s;
    logic [PCNT_W-1:0]         prime_cnt_r, prime_cnt_next_s;
    logic [CIRC_BUF_BITS-1:0]  last_good_r, last_good_next_s;
    logic                      resync_req_r, resync_req_s;
    logic                      lock_r, lock_s;

    logic [CIRC_BUF_BITS-1:0]  read_frame_s;
    logic [CIRC_BUF_BITS-1:0]  lag_s;
    logic                      frame_end_s;
    logic                      in_order_s;
    logic                      lag_bad_s;
    logic                      underrun_s;
    logic                      run_fault_s;

    frame_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (frame_valid_i),
        .expire_o (underrun_s)
    );

    assign read_frame_s = ram_read_addr_i[ADDR_W-1 -: CIRC_BUF_BITS];
    assign frame_end_s  = &ram_read_addr_i[FRAME_BITS-1:0];
    assign lag_s        = CIRC_BUF_BITS'(frame_lag(32'(last_good_r), 32'(read_frame_s), CIRC_BUF_BITS));
    assign in_order_s   = (frame_idx_i == CIRC_BUF_BITS'(next_frame_idx(32'(last_good_r), CIRC_BUF_BITS)));
    assign lag_bad_s    = frame_end_s && ((lag_s < LAG_MIN) || (lag_s > LAG_MAX));
    // Any single cause (or several at once) yields exactly one RUN->RESYNC transition.
    assign run_fault_s  = (frame_valid_i && !in_order_s) || lag_bad_s || underrun_s || !i2s_running_i;

    // State, prime counter and newest-frame register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            prime_cnt_r <= PCNT_ZERO;
            last_good_r <= {CIRC_BUF_BITS{1'b0}};
        end else begin
            state_r     <= state_next_s;
            prime_cnt_r <= prime_cnt_next_s;
            last_good_r <= last_good_next_s;
        end
    end

    // Next-state and prime/index bookkeeping.
    always_comb begin
        state_next_s     = state_r;
        prime_cnt_next_s = prime_cnt_r;
        last_good_next_s = last_good_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_valid_i) begin
                    state_next_s     = ST_PRIME;
                    prime_cnt_next_s = PCNT_ONE;
                    last_good_next_s = frame_idx_i;
                end else begin
                    state_next_s     = ST_IDLE;
                end
            end
            ST_PRIME: begin
                if (frame_valid_i) begin
                    last_good_next_s = frame_idx_i;
                    if (in_order_s) begin
                        prime_cnt_next_s = (prime_cnt_r == PCNT_TARGET) ? PCNT_TARGET
                                                                        : prime_cnt_r + PCNT_ONE;
                    end else begin
                        prime_cnt_next_s = PCNT_ONE;
                    end
                end else begin
                    prime_cnt_next_s = prime_cnt_r;
                end
                // Release only on a read frame boundary with a full in-order streak.
                if (frame_valid_i && !in_order_s) begin
                    state_next_s = ST_PRIME;
                end else if ((prime_cnt_r == PCNT_TARGET) && frame_end_s && i2s_running_i) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_PRIME;
                end
            end
            ST_RUN: begin
                if (frame_valid_i) begin
                    last_good_next_s = frame_idx_i;
                end else begin
                    last_good_next_s = last_good_r;
                end
                if (run_fault_s) begin
                    state_next_s     = ST_RESYNC;
                    prime_cnt_next_s = PCNT_ZERO;
                end else begin
                    state_next_s     = ST_RUN;
                end
            end
            ST_RESYNC: begin
                if (frame_valid_i) begin
                    state_next_s     = ST_PRIME;
                    prime_cnt_next_s = PCNT_ONE;
                    last_good_next_s = frame_idx_i;
                end else begin
                    state_next_s     = ST_RESYNC;
                    prime_cnt_next_s = PCNT_ZERO;
                end
            end
            default: begin
                state_next_s     = ST_IDLE;
                prime_cnt_next_s = PCNT_ZERO;
                last_good_next_s = {CIRC_BUF_BITS{1'b0}};
            end
        endcase
    end

    // Transmitter control values for the upcoming state.
    always_comb begin
        resync_req_s = 1'b1;
        lock_s       = 1'b0;
        if (state_next_s == ST_RUN) begin
            resync_req_s = 1'b0;
            lock_s       = 1'b1;
        end else begin
            resync_req_s = 1'b1;
            lock_s       = 1'b0;
        end
    end

    // Registered transmitter control outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resync_req_r <= 1'b1;
            lock_r       <= 1'b0;
        end else begin
            resync_req_r <= resync_req_s;
            lock_r       <= lock_s;
        end
    end

    assign resync_req_o          = resync_req_r;
    assign lock_o                = lock_r;
    assign last_good_frame_idx_o = last_good_r;
    assign underrun_o            = underrun_s;

`ifdef I2S_FRAME_SCHED_STATS_EN
    logic [7:0] resync_count_r;
    logic       resync_entry_s;

    assign resync_entry_s = (state_r == ST_RUN) && (state_next_s == ST_RESYNC);

    // Saturating count of RUN->RESYNC entries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resync_count_r <= 8'd0;
        end else if (resync_entry_s && (resync_count_r != 8'hFF)) begin
            resync_count_r <= resync_count_r + 8'd1;
        end else begin
            resync_count_r <= resync_count_r;
        end
    end

    assign resync_count_o = resync_count_r;
`else
    assign resync_count_o = 8'd0;
`endif

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Randomized self-checking bench for i2s_frame_scheduler against a cycle-level reference model.
module tb_i2s_frame_scheduler;

    localparam int T    = 1024;
    localparam int TGT  = 2;
    localparam int LMIN = 1;
    localparam int LMAX = 6;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        frame_valid_i;
    logic [2:0]  frame_idx_i;
    logic [10:0] ram_read_addr_i;
    logic        i2s_running_i;
    logic        resync_req_o;
    logic [2:0]  last_good_frame_idx_o;
    logic        lock_o;
    logic        underrun_o;
    logic [7:0]  resync_count_o;

    always #5 clk = ~clk;

    i2s_frame_scheduler dut (
        .clk_i                 (clk),
        .rst_ni                (rst_ni),
        .frame_valid_i         (frame_valid_i),
        .frame_idx_i           (frame_idx_i),
        .ram_read_addr_i       (ram_read_addr_i),
        .i2s_running_i         (i2s_running_i),
        .resync_req_o          (resync_req_o),
        .last_good_frame_idx_o (last_good_frame_idx_o),
        .lock_o                (lock_o),
        .underrun_o            (underrun_o),
        .resync_count_o        (resync_count_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: scheduler mode, newest frame, in-order streak, quiet time, resync tally.
    typedef enum int {M_IDLE, M_PRIME, M_RUN, M_RESYNC} mode_t;
    mode_t m_mode;
    int    m_last, m_streak, m_quiet, m_resyncs;
    bit    m_und;

    function automatic int wrap8(input int x);
        return ((x % 8) + 8) % 8;
    endfunction

    function automatic int exp_count();
`ifdef I2S_FRAME_SCHED_STATS_EN
        return m_resyncs;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_last = 0; m_streak = 0; m_quiet = 0; m_resyncs = 0; m_und = 1'b0;
    endtask

    int last_addr;

    task automatic step(input bit v, input int ix, input int a, input bit run);
        int rf, lag, nl, ns, nq, nr;
        bit fe, inord, nu;
        mode_t nm;
        frame_valid_i   = v;
        frame_idx_i     = ix[2:0];
        ram_read_addr_i = a[10:0];
        i2s_running_i   = run;
        last_addr       = a;
        rf    = (a / 256) % 8;
        fe    = ((a % 256) == 255);
        lag   = wrap8(m_last - rf);
        inord = (ix == wrap8(m_last + 1));
        if (v) begin
            nq = 0; nu = 1'b0;
        end else if (m_quiet < T - 1) begin
            nq = m_quiet + 1; nu = (nq == T - 1);
        end else begin
            nq = m_quiet; nu = 1'b0;
        end
        nm = m_mode; nl = m_last; ns = m_streak; nr = m_resyncs;
        case (m_mode)
            M_IDLE, M_RESYNC: begin
                if (v) begin nm = M_PRIME; ns = 1; nl = ix; end
                else if (m_mode == M_RESYNC) ns = 0;
            end
            M_PRIME: begin
                if (v) begin
                    nl = ix;
                    ns = inord ? ((m_streak + 1 > TGT) ? TGT : m_streak + 1) : 1;
                end
                if (!(v && !inord) && m_streak == TGT && fe && run) nm = M_RUN;
            end
            M_RUN: begin
                if (v) nl = ix;
                if ((v && !inord) || (fe && (lag < LMIN || lag > LMAX)) || m_und || !run) begin
                    nm = M_RESYNC; ns = 0;
                    nr = (m_resyncs < 255) ? m_resyncs + 1 : 255;
                end
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
        m_mode = nm; m_last = nl; m_streak = ns; m_quiet = nq; m_und = nu; m_resyncs = nr;
        chk("resync_req", 32'(resync_req_o), 32'(m_mode != M_RUN));
        chk("lock", 32'(lock_o), 32'(m_mode == M_RUN));
        chk("last_good", 32'(last_good_frame_idx_o), 32'(m_last));
        chk("underrun", 32'(underrun_o), 32'(m_und));
        chk("resync_count", 32'(resync_count_o), 32'(exp_count()));
    endtask

    // Stimulus generator: reader walks the buffer, producer emits a frame every gap+1 cycles.
    int rd_addr, wr_idx, phase, gap, run_hold, last_ix;
    bit freeze_rd, produce, running, random_mode, last_v;

    task automatic tick();
        bit v, run_eff;
        v = produce && (phase >= gap);
        run_eff = running && (run_hold == 0);
        if (run_hold > 0) run_hold--;
        step(v, wr_idx, rd_addr, run_eff);
        last_v = v;
        if (v) begin
            last_ix = wr_idx;
            wr_idx  = (wr_idx + 1) % 8;
            phase   = 0;
            if (random_mode) begin
                gap = $urandom_range(272, 240);
                if ($urandom_range(7, 0) == 0) wr_idx = (wr_idx + $urandom_range(6, 1)) % 8;
            end
        end else if (phase < 1000) begin
            phase++;
        end
        if (!freeze_rd) rd_addr = (rd_addr + 1) % 2048;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        frame_valid_i = 1'b0;
        #1;
        chk("rst_resync_req", 32'(resync_req_o), 32'd1);
        chk("rst_last_good", 32'(last_good_frame_idx_o), 32'd0);
        chk("rst_lock", 32'(lock_o), 32'd0);
        chk("rst_underrun", 32'(underrun_o), 32'd0);
        chk("rst_count", 32'(resync_count_o), 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic run_until_lock(input bit val, input int budget, input string tag);
        int n;
        n = 0;
        while (lock_o !== val && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(lock_o), 32'(val));
    endtask

    task automatic run_until_emit(input int budget, input string tag);
        int n;
        n = 0;
        tick();
        while (!last_v && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(last_v), 32'd1);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int prev, pulses, n;
        bit wrapped;
        rst_ni = 1'b0; frame_valid_i = 1'b0; frame_idx_i = 3'd0;
        ram_read_addr_i = 11'd0; i2s_running_i = 1'b0;
        rd_addr = 11'h700; wr_idx = 1; phase = 127; gap = 255;
        produce = 1'b1; freeze_rd = 1'b0; running = 1'b1; random_mode = 1'b0;
        run_hold = 0; last_v = 1'b0; last_ix = 0; last_addr = 0;
        model_reset();
        reset_dut();

        // Frames 1,2 then release on the next read frame boundary.
        run_until_lock(1'b1, 1000, "t1_lock");
        chk("t1_release_addr", 32'(last_addr), 32'h0FF);
        chk("t1_last_good", 32'(last_good_frame_idx_o), 32'd2);
        chk("t1_resync_req", 32'(resync_req_o), 32'd0);

        // Steady RUN through the index wrap.
        wrapped = 1'b0;
        prev = int'(last_good_frame_idx_o);
        repeat (1700) begin
            tick();
            if (prev == 7 && last_good_frame_idx_o == 3'd0) wrapped = 1'b1;
            prev = int'(last_good_frame_idx_o);
        end
        chk("t2_wrap", 32'(wrapped), 32'd1);
        chk("t2_last_good", 32'(last_good_frame_idx_o), 32'd1);
        chk("t2_lock", 32'(lock_o), 32'd1);
        chk("t2_count", 32'(resync_count_o), 32'd0);

        // Frame 5 followed by frame 7.
        n = 0;
        tick();
        while (!(last_v && last_ix == 5) && n < 2400) begin tick(); n++; end
        chk("t3_saw5", 32'(last_ix), 32'd5);
        wr_idx = 7;
        run_until_lock(1'b0, 400, "t3_resync");
        chk("t3_resync_req", 32'(resync_req_o), 32'd1);
        chk("t3_last_good", 32'(last_good_frame_idx_o), 32'd7);
`ifdef I2S_FRAME_SCHED_STATS_EN
        chk("t3_count", 32'(resync_count_o), 32'd1);
`else
        chk("t3_count", 32'(resync_count_o), 32'd0);
`endif
        run_until_lock(1'b1, 1200, "t3_relock");
        chk("t3_relock_idx", 32'(last_good_frame_idx_o), 32'd1);

        // Producer stall with the reader parked mid-frame.
        run_until_emit(300, "t4_emit");
        produce = 1'b0; freeze_rd = 1'b1; pulses = 0;
        repeat (1100) begin
            tick();
            if (underrun_o === 1'b1) pulses++;
        end
        chk("t4_underrun_pulses", 32'(pulses), 32'd1);
        chk("t4_lock", 32'(lock_o), 32'd0);
        chk("t4_resync_req", 32'(resync_req_o), 32'd1);
        produce = 1'b1; freeze_rd = 1'b0;
        run_until_lock(1'b1, 1500, "t4_relock");

        // Reader frozen until the lag reaches 7, then released to the next boundary.
        if (rd_addr % 256 == 255) tick();
        freeze_rd = 1'b1;
        n = 0;
        while (wrap8(int'(last_good_frame_idx_o) - rd_addr / 256) != 7 && n < 2500) begin tick(); n++; end
        chk("t5_lag7", 32'(wrap8(int'(last_good_frame_idx_o) - rd_addr / 256)), 32'd7);
        freeze_rd = 1'b0;
        run_until_lock(1'b0, 300, "t5_resync");
        chk("t5_at_frame_end", 32'(last_addr % 256), 32'd255);
`ifdef I2S_FRAME_SCHED_STATS_EN
        chk("t5_count", 32'(resync_count_o), 32'd3);
`else
        chk("t5_count", 32'(resync_count_o), 32'd0);
`endif
        rd_addr = wrap8(int'(last_good_frame_idx_o) - 2) * 256 + rd_addr % 256;
        run_until_lock(1'b1, 1500, "t5_relock");

        // Reset mid-RUN, then the first frame restarts priming.
        repeat (100) tick();
        reset_dut();
        run_until_emit(300, "t6_emit");
        chk("t6_prime_resync", 32'(resync_req_o), 32'd1);
        chk("t6_prime_lock", 32'(lock_o), 32'd0);
        chk("t6_prime_idx", 32'(last_good_frame_idx_o), 32'(last_ix));
        run_until_lock(1'b1, 800, "t6_relock");

        // A frame in the exact cycle the watchdog would expire suppresses the underrun.
        run_until_emit(300, "t7_emit");
        produce = 1'b0; freeze_rd = 1'b1;
        repeat (T - 2) tick();
        produce = 1'b1;
        tick();
        chk("t7_valid_taken", 32'(last_v), 32'd1);
        chk("t7_no_underrun", 32'(underrun_o), 32'd0);
        freeze_rd = 1'b0;
        repeat (5) tick();

        // Randomized soak: jittered frame spacing, skipped indices, transmitter dropouts.
        random_mode = 1'b1;
        gap = $urandom_range(272, 240);
        repeat (4000) begin
            if (run_hold == 0 && $urandom_range(399, 0) == 0) run_hold = $urandom_range(4, 1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_frame_scheduler.md
Name: i2s_frame_scheduler

Overview:
- Sequences the I2S MSB transmitter against the channel buffer that an upstream producer (ADAT decoder) fills one frame at a time.
- Tracks the newest complete frame and drives the transmitter's resync_req / last_good_frame_idx inputs.
- Measures the lag between the write frame and the transmitter read frame, and forces a realignment on drift, out-of-order frames or producer stall.
- Sits between the producer frame-done strobe and the transmitter's control inputs.

Parameters:
- CIRC_BUF_BITS, 3: log2 of the number of frames in the circular channel buffer.
- FRAME_BITS, 8: log2 of the bits per frame (256-bit frames, 2048-bit buffer).
- TARGET_LAG, 2: consecutive in-order frames required in PRIME before release.
- MIN_LAG, 1: smallest legal write-to-read frame distance in RUN.
- MAX_LAG, 6: largest legal write-to-read frame distance in RUN.
- TIMEOUT_CYCLES, 1024: clk cycles without frame_valid_i before a stall is declared.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- frame_valid_i  in  1  single-cycle pulse; producer finished writing a frame.
- frame_idx_i  in  CIRC_BUF_BITS  index of the frame just completed; sampled with frame_valid_i.
- ram_read_addr_i  in  CIRC_BUF_BITS+FRAME_BITS  transmitter buffer read address.
- i2s_running_i  in  1  transmitter running flag.
- resync_req_o  out  1  registered; high means the transmitter must realign to last_good_frame_idx_o.
- last_good_frame_idx_o  out  CIRC_BUF_BITS  registered; newest complete frame.
- lock_o  out  1  registered; high only in RUN.
- underrun_o  out  1  one-cycle pulse on producer timeout.
- resync_count_o  out  8  saturating count of RUN->RESYNC events.

Behaviour:
- Reset: state=IDLE, resync_req_o=1, last_good_frame_idx_o=0, lock_o=0, underrun_o=0, resync_count_o=0, internal prime counter=0, watchdog=0. Reset is asynchronous and can occur mid-operation; all state returns to these values immediately.
- Derived signals:
  - read_frame = ram_read_addr_i[top CIRC_BUF_BITS].
  - frame_end = ram_read_addr_i[FRAME_BITS-1:0] all ones.
  - lag = (last_good_frame_idx_o - read_frame) mod 2^CIRC_BUF_BITS, computed in CIRC_BUF_BITS width.
- In-order frame: frame_idx_i == last_good_frame_idx_o+1 (mod wrap). Frame index 7 followed by 0 is in order.
- Every accepted frame_valid_i updates last_good_frame_idx_o on the next clock (1-cycle latency), in all states except IDLE->PRIME, where it loads frame_idx_i directly.
- Watchdog:
  - Counts clk cycles since the last frame_valid_i; clears on frame_valid_i.
  - On reaching TIMEOUT_CYCLES-1: pulses underrun_o for one cycle, then holds at terminal value until the next frame_valid_i.
- IDLE: resync_req_o=1. Leave on first frame_valid_i -> PRIME with prime counter=1.
- PRIME: resync_req_o=1.
  - In-order frame: counter increments, saturating at TARGET_LAG.
  - Out-of-order frame: counter=1 and index reloads.
  - Once counter==TARGET_LAG and frame_end and i2s_running_i: next cycle go to RUN, resync_req_o=0, lock_o=1. Release is aligned to a frame boundary only.
  - If i2s_running_i=0, remain in PRIME.
- RUN: go to RESYNC on the next cycle if any of the following holds:
  - an out-of-order frame arrives;
  - frame_end is seen with lag<MIN_LAG or lag>MAX_LAG;
  - underrun fires;
  - i2s_running_i falls.
  - On entry to RESYNC, resync_count_o increments (saturates at 255).
- RESYNC: resync_req_o=1, lock_o=0, prime counter=0. Go to PRIME on the next frame_valid_i; the counter counts that frame as 1.
- Simultaneous frame_valid_i and timeout in the same cycle: frame_valid_i wins, watchdog clears, no underrun.
- Simultaneous out-of-order frame and lag violation: a single RESYNC entry, count increments by 1.

Optional Feature:
- Macro I2S_FRAME_SCHED_STATS_EN.
- Defined: resync_count_o is live as described.
- Undefined: resync_count_o is tied to 0 and the counter logic is not instantiated.

Decomposition:
- Package i2s_sched_pkg holds:
  - the state enum (IDLE, PRIME, RUN, RESYNC);
  - the lag and frame-index width functions;
  - default lag constants.
- One sub-module, frame_watchdog: a parameterised timeout counter with a clear input and a single-pulse expiry output.

Test Plan:
- Reset then frames 1,2 at 256-cycle spacing with transmitter running → resync_req_o falls exactly one cycle after ram_read_addr_i reaches the next x_FF boundary; lock_o=1; last_good_frame_idx_o=2.
- Steady RUN with frames 3..7,0,1 → no resync; last_good_frame_idx_o wraps 7→0; resync_count_o stays 0.
- In RUN, frame 5 then frame 7 → RESYNC next cycle; resync_req_o=1; resync_count_o=1; two further in-order frames plus frame_end → RUN.
- Withhold frame_valid_i for 1024 cycles in RUN → one-cycle underrun_o pulse, RESYNC, lock_o=0.
- Freeze ram_read_addr_i so lag reaches 7 → RESYNC at the next frame_end; with I2S_FRAME_SCHED_STATS_EN undefined, resync_count_o remains 0.
- Assert rst_ni low mid-RUN for 3 cycles → all outputs at reset values immediately; the next frame starts PRIME.
